// File: rtl/if_pc_redirect.sv
// rtl/if_pc_redirect.sv - fetch PC register with EX-stage redirect, stall and pipeline flush control
//
// Ports:
//   clk           in   1  rising-edge clock
//   rst_n         in   1  synchronous active-low reset
//   PcSrc         in   1  EX-stage redirect request
//   TargetPc      in  32  redirect target (low two bits ignored)
//   Stall         in   1  hold the fetch PC
//   ImemReady     in   1  instruction memory accepts the fetch this cycle
//   Pc            out 32  registered fetch address
//   ImemReq       out  1  fetch request valid
//   FlushIFID     out  1  squash IF/ID at the coming edge
//   FlushIDEX     out  1  squash ID/EX at the coming edge
//   RedirectCount out 16  saturating count of accepted redirects
module if_pc_redirect #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PcSrc,
  input  logic [31:0] TargetPc,
  input  logic        Stall,
  input  logic        ImemReady,
  output logic [31:0] Pc,
  output logic        ImemReq,
  output logic        FlushIFID,
  output logic        FlushIDEX,
  output logic [15:0] RedirectCount
);

  localparam logic [1:0] ST_BOOT  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_REDIR = 2'd2;

  logic [1:0]  r_state;
  logic [31:0] r_pc;
  logic [15:0] r_cnt;

  logic        w_active;
  logic        w_redirect;
  logic        w_advance;
  logic [31:0] w_target;

  // Only RUN and REDIR fetch; BOOT ignores PcSrc entirely.
  assign w_active   = (r_state == ST_RUN) || (r_state == ST_REDIR);
  assign w_redirect = rst_n && w_active && PcSrc;
  // Stall and a busy memory both hold the PC, but a redirect overrides them.
  assign w_advance  = ImemReady && !Stall;
  assign w_target   = {TargetPc[31:2], 2'b00};

  // Reset forces the boot-time output pattern immediately, not only after the edge.
  assign ImemReq   = rst_n && w_active;
  assign FlushIFID = !rst_n || (r_state == ST_BOOT) || (r_state == ST_REDIR) || w_redirect;
  assign FlushIDEX = w_redirect;

  assign Pc            = r_pc;
  assign RedirectCount = r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
      r_pc    <= {RESET_PC[31:2], 2'b00};
      r_cnt   <= 16'h0000;
    end else begin
      if (w_redirect) begin
        r_pc    <= w_target;
        r_state <= ST_REDIR;
        if (r_cnt != 16'hFFFF) begin
          r_cnt <= r_cnt + 16'h0001;
        end
      end else begin
        case (r_state)
          ST_BOOT: begin
            r_state <= ST_RUN;
          end
          ST_RUN: begin
            if (w_advance) begin
              r_pc <= r_pc + 32'd4;
            end
          end
          ST_REDIR: begin
            if (w_advance) begin
              r_pc    <= r_pc + 32'd4;
              r_state <= ST_RUN;
            end
          end
          default: begin
            r_state <= ST_BOOT;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_pc_redirect.sv
// tb/tb_if_pc_redirect.sv - table-driven scoreboard bench for if_pc_redirect
module tb_if_pc_redirect;

  logic        clk;
  logic        rst_n;
  logic        PcSrc;
  logic [31:0] TargetPc;
  logic        Stall;
  logic        ImemReady;
  logic [31:0] Pc;
  logic        ImemReq;
  logic        FlushIFID;
  logic        FlushIDEX;
  logic [15:0] RedirectCount;

  if_pc_redirect #(.RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PcSrc        (PcSrc),
    .TargetPc     (TargetPc),
    .Stall        (Stall),
    .ImemReady    (ImemReady),
    .Pc           (Pc),
    .ImemReq      (ImemReq),
    .FlushIFID    (FlushIFID),
    .FlushIDEX    (FlushIDEX),
    .RedirectCount(RedirectCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        pcsrc;
    logic        stall;
    logic        ready;
    logic [31:0] tgt;
    logic        e_req;
    logic        e_ifid;
    logic        e_idex;
    logic [31:0] e_pc;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic r, input logic p, input logic s, input logic rd,
                              input logic [31:0] t, input logic q, input logic fi,
                              input logic fx, input logic [31:0] pc, input logic [15:0] c);
    vec_t v;
    v.rst_n = r;  v.pcsrc = p;  v.stall = s;  v.ready = rd;  v.tgt = t;
    v.e_req = q;  v.e_ifid = fi; v.e_idex = fx; v.e_pc = pc; v.e_cnt = c;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, check combinational outputs mid-cycle,
  // then check registered state just after the edge.
  task automatic apply(input vec_t v, input string tag);
    vec_t e;
    rst_n     = v.rst_n;
    PcSrc     = v.pcsrc;
    Stall     = v.stall;
    ImemReady = v.ready;
    TargetPc  = v.tgt;
    sb.push_back(v);
    @(negedge clk);
    e = sb[0];
    chk({tag, ".ImemReq"},   {31'd0, ImemReq},   {31'd0, e.e_req});
    chk({tag, ".FlushIFID"}, {31'd0, FlushIFID}, {31'd0, e.e_ifid});
    chk({tag, ".FlushIDEX"}, {31'd0, FlushIDEX}, {31'd0, e.e_idex});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".Pc"},    Pc, e.e_pc);
    chk({tag, ".Count"}, {16'd0, RedirectCount}, {16'd0, e.e_cnt});
  endtask

  initial begin
    rst_n = 1'b0; PcSrc = 1'b0; Stall = 1'b0; ImemReady = 1'b1; TargetPc = 32'h0;

    //          rst pc  st  rdy target         req fi fx pc             cnt
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,         0, 1, 0, 32'h0,         16'd0)); // 0 reset
    vecs.push_back(mk(1, 0, 0, 1, 32'h0,         0, 1, 0, 32'h0,         16'd0)); // 1 BOOT->RUN
    vecs.push_back(mk(1, 0, 0, 1, 32'h0,         1, 0, 0, 32'h4,         16'd0)); // 2
    vecs.push_back(mk(1, 0, 0, 1, 32'h0,         1, 0, 0, 32'h8,         16'd0)); // 3
    vecs.push_back(mk(1, 0, 0, 1, 32'h0,         1, 0, 0, 32'hC,         16'd0)); // 4
    vecs.push_back(mk(1, 0, 0, 1, 32'h0,         1, 0, 0, 32'h10,        16'd0)); // 5
    vecs.push_back(mk(1, 1, 0, 1, 32'h103,       1, 1, 1, 32'h100,       16'd1)); // 6 redirect
    vecs.push_back(mk(1, 0, 0, 1, 32'h0,         1, 1, 0, 32'h104,       16'd1)); // 7 REDIR->RUN
    vecs.push_back(mk(1, 0, 0, 1, 32'h0,         1, 0, 0, 32'h108,       16'd1)); // 8
    vecs.push_back(mk(1, 0, 1, 1, 32'h0,         1, 0, 0, 32'h108,       16'd1)); // 9 stall
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         1, 0, 0, 32'h108,       16'd1)); // 10 not ready
    vecs.push_back(mk(1, 1, 1, 1, 32'h200,       1, 1, 1, 32'h200,       16'd2)); // 11 redirect beats stall
    vecs.push_back(mk(1, 0, 1, 1, 32'h0,         1, 1, 0, 32'h200,       16'd2)); // 12
    vecs.push_back(mk(1, 0, 1, 1, 32'h0,         1, 1, 0, 32'h200,       16'd2)); // 13
    vecs.push_back(mk(1, 0, 0, 1, 32'h0,         1, 1, 0, 32'h204,       16'd2)); // 14
    vecs.push_back(mk(1, 1, 0, 1, 32'h302,       1, 1, 1, 32'h300,       16'd3)); // 15
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         1, 1, 0, 32'h300,       16'd3)); // 16
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         1, 1, 0, 32'h300,       16'd3)); // 17
    vecs.push_back(mk(1, 0, 0, 0, 32'h0,         1, 1, 0, 32'h300,       16'd3)); // 18
    vecs.push_back(mk(1, 1, 0, 0, 32'h400,       1, 1, 1, 32'h400,       16'd4)); // 19 REDIR re-target
    vecs.push_back(mk(0, 1, 0, 1, 32'h500,       0, 1, 0, 32'h0,         16'd0)); // 20 reset in REDIR
    vecs.push_back(mk(1, 1, 0, 1, 32'h600,       0, 1, 0, 32'h0,         16'd0)); // 21 BOOT ignores PcSrc
    vecs.push_back(mk(1, 0, 0, 1, 32'h0,         1, 0, 0, 32'h4,         16'd0)); // 22

    @(posedge clk);
    #1;
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
    end

    // Address wrap after a redirect to the top word (low target bits ignored).
    apply(mk(0, 0, 0, 1, 32'h0,         0, 1, 0, 32'h0,         16'd0), "wrap.rst");
    apply(mk(1, 0, 0, 1, 32'h0,         0, 1, 0, 32'h0,         16'd0), "wrap.boot");
    apply(mk(1, 1, 0, 1, 32'hFFFF_FFFF, 1, 1, 1, 32'hFFFF_FFFC, 16'd1), "wrap.redir");
    apply(mk(1, 0, 0, 1, 32'h0,         1, 1, 0, 32'h0,         16'd1), "wrap.adv");
    apply(mk(1, 0, 0, 1, 32'h0,         1, 0, 0, 32'h4,         16'd1), "wrap.run");

    // Counter saturation: 65535 redirects in total, then one more.
    apply(mk(0, 0, 0, 1, 32'h0,         0, 1, 0, 32'h0,         16'd0), "sat.rst");
    apply(mk(1, 0, 0, 1, 32'h0,         0, 1, 0, 32'h0,         16'd0), "sat.boot");
    rst_n = 1'b1; PcSrc = 1'b1; TargetPc = 32'h10; Stall = 1'b0; ImemReady = 1'b1;
    for (int k = 0; k < 65534; k++) begin
      @(posedge clk);
    end
    #1;
    apply(mk(1, 1, 0, 1, 32'h10,        1, 1, 1, 32'h10,        16'hFFFF), "sat.full");
    apply(mk(1, 1, 0, 1, 32'h20,        1, 1, 1, 32'h20,        16'hFFFF), "sat.hold");
    apply(mk(1, 0, 0, 1, 32'h0,         1, 1, 0, 32'h24,        16'hFFFF), "sat.exit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
